// File: rtl/lsu_hs.sv
`default_nettype none
// ============================================================================
// Module      : lsu_hs
// Description : Load/store unit between EXU and the SimpleBus data port.
//               One outstanding op. It issues a handshaked bus request,
//               waits a variable number of cycles for the response (with a
//               timeout), then returns an extended load result or a store
//               acknowledge with an error flag.
// Revision    : 1.0 - initial handshaked release
// ============================================================================
module lsu_hs #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ren,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rdata,
    output logic              out_err,
    output logic              busy,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wen,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wmask,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0]      C_SZ_BYTE = 2'b00;
    localparam logic [1:0]      C_SZ_HALF = 2'b01;
    localparam logic [1:0]      C_SZ_WORD = 2'b10;
    localparam logic [TO_W-1:0] C_TIMEOUT = TO_W'(TIMEOUT);
    localparam bit              C_TO_EN   = (TIMEOUT != 0);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                bus_wen_q, bus_wen_d;
    logic [31:0]         bus_wdata_q, bus_wdata_d;
    logic [3:0]          bus_wmask_q, bus_wmask_d;
    logic [1:0]          size_q, size_d;
    logic                unsigned_q, unsigned_d;
    logic [1:0]          lane_q, lane_d;
    logic [31:0]         out_rdata_q, out_rdata_d;
    logic                out_err_q, out_err_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;

    logic                w_misaligned;
    logic                w_illegal;
    logic                w_noop;
    logic [31:0]         w_lane_wdata;
    logic [3:0]          w_lane_wmask;
    logic [31:0]         w_shifted;
    logic [31:0]         w_load_data;
    logic [TO_W-1:0]     w_cnt_inc;

    // Request classification of the op presented by EXU
    always_comb begin
        w_misaligned = ((in_size == C_SZ_HALF) && in_addr[0]) ||
                       ((in_size == C_SZ_WORD) && (in_addr[1:0] != 2'b00));
        w_illegal    = (in_ren && in_wen) || (in_size == 2'b11) || w_misaligned;
        w_noop       = !in_ren && !in_wen;
    end

    // Store data replication across byte lanes and the matching write mask
    always_comb begin
        w_lane_wdata = in_wdata;
        w_lane_wmask = 4'b0000;
        case (in_size)
            C_SZ_BYTE: begin
                w_lane_wdata = {4{in_wdata[7:0]}};
                w_lane_wmask = 4'b0001 << in_addr[1:0];
            end
            C_SZ_HALF: begin
                w_lane_wdata = {2{in_wdata[15:0]}};
                w_lane_wmask = 4'b0011 << in_addr[1:0];
            end
            C_SZ_WORD: w_lane_wmask = 4'b1111;
            default:   w_lane_wmask = 4'b0000;
        endcase
    end

    // Load alignment: shift the addressed lane down, then sign/zero extend
    always_comb begin
        w_shifted = bus_rdata >> {lane_q, 3'b000};
        case (size_q)
            C_SZ_BYTE: w_load_data = unsigned_q ? {24'h0, w_shifted[7:0]}
                                                : {{24{w_shifted[7]}}, w_shifted[7:0]};
            C_SZ_HALF: w_load_data = unsigned_q ? {16'h0, w_shifted[15:0]}
                                                : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:   w_load_data = w_shifted;
        endcase
    end

    assign w_cnt_inc = cnt_q + TO_W'(1);

    // Next-state and datapath update for the IDLE/REQ/WAIT/RESP sequence
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wen_d   = bus_wen_q;
        bus_wdata_d = bus_wdata_q;
        bus_wmask_d = bus_wmask_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        lane_d      = lane_q;
        out_rdata_d = out_rdata_q;
        out_err_d   = out_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bus_addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
                    bus_wen_d   = in_wen;
                    bus_wdata_d = w_lane_wdata;
                    bus_wmask_d = in_wen ? w_lane_wmask : 4'b0000;
                    size_d      = in_size;
                    unsigned_d  = in_unsigned;
                    lane_d      = in_addr[1:0];
                    if (w_illegal) begin
                        out_err_d   = 1'b1;
                        out_rdata_d = 32'h0;
                        state_d     = S_RESP;
                    end else if (w_noop) begin
                        out_err_d   = 1'b0;
                        out_rdata_d = 32'h0;
                        state_d     = S_RESP;
                    end else begin
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response arriving in the timeout cycle takes priority
                if (bus_rsp_valid) begin
                    out_err_d   = bus_rsp_err;
                    out_rdata_d = (bus_wen_q || bus_rsp_err) ? 32'h0 : w_load_data;
                    state_d     = S_RESP;
                end else if (C_TO_EN && (w_cnt_inc == C_TIMEOUT)) begin
                    out_err_d   = 1'b1;
                    out_rdata_d = 32'h0;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any op in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_addr_q  <= '0;
            bus_wen_q   <= 1'b0;
            bus_wdata_q <= 32'h0;
            bus_wmask_q <= 4'h0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            lane_q      <= 2'b00;
            out_rdata_q <= 32'h0;
            out_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wen_q   <= bus_wen_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            lane_q      <= lane_d;
            out_rdata_q <= out_rdata_d;
            out_err_q   <= out_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign bus_req_valid = (state_q == S_REQ);
    assign out_valid     = (state_q == S_RESP);
    assign bus_addr      = bus_addr_q;
    assign bus_wen       = bus_wen_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_wmask     = bus_wmask_q;
    assign out_rdata     = out_rdata_q;
    assign out_err       = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_hs
// Description : Directed self-checking bench for lsu_hs (TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_hs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_ren = 1'b0;
    logic        in_wen = 1'b0;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_wdata = 32'h0;
    logic [1:0]  in_size = 2'b00;
    logic        in_unsigned = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        busy;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_rsp_err = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    lsu_hs #(.ADDR_W(32), .TIMEOUT(4), .TO_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size), .in_unsigned(in_unsigned),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .busy(busy),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
        .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata), .bus_rsp_err(bus_rsp_err)
    );

    always #5 clk = ~clk;

    // Load vectors: addr, size, unsigned, bus word, expected bus_addr, expected result
    logic [31:0] ld_addr  [7] = '{32'h8000_0003, 32'h8000_0002, 32'h8000_0000, 32'h8000_0001,
                                  32'h8000_0004, 32'h8000_000D, 32'h8000_0002};
    logic [1:0]  ld_size  [7] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1};
    logic        ld_uns   [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ld_rdata [7] = '{32'h80AA_BBCC, 32'h80AA_BBCC, 32'h80AA_BBCC, 32'h80AA_BBCC,
                                  32'h80AA_BBCC, 32'h0011_7F00, 32'h7FFE_1234};
    logic [31:0] ld_baddr [7] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                  32'h8000_0004, 32'h8000_000C, 32'h8000_0000};
    logic [31:0] ld_exp   [7] = '{32'hFFFF_FF80, 32'h0000_80AA, 32'hFFFF_BBCC, 32'h0000_00BB,
                                  32'h80AA_BBCC, 32'h0000_007F, 32'h0000_7FFE};

    // Store vectors: addr, data, size, request-ready delay, expected bus fields
    logic [31:0] st_addr  [4] = '{32'h8000_0001, 32'h8000_0006, 32'h8000_0008, 32'h8000_0003};
    logic [31:0] st_wdata [4] = '{32'hDEAD_BE12, 32'hABCD_5678, 32'hCAFE_F00D, 32'h0000_00A5};
    logic [1:0]  st_size  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    int          st_delay [4] = '{2, 0, 1, 0};
    logic [31:0] st_baddr [4] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0000};
    logic [31:0] st_bdata [4] = '{32'h1212_1212, 32'h5678_5678, 32'hCAFE_F00D, 32'hA5A5_A5A5};
    logic [3:0]  st_mask  [4] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000};

    // Ops rejected or completed without a bus request
    logic        er_ren  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        er_wen  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] er_addr [7] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000,
                                 32'h8000_0000, 32'h8000_0001, 32'h8000_0003};
    logic [1:0]  er_size [7] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1};
    logic        er_exp  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one op for a single cycle (accepted at the next rising edge)
    task automatic start_op(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        in_valid = 1'b1; in_ren = ren; in_wen = wen; in_addr = addr;
        in_wdata = wdata; in_size = size; in_unsigned = uns;
        tick();
        in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
    endtask

    task automatic release_resp();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++;
            $display("FAIL reset ready/busy: got %b/%b want 1/0", in_ready, busy); end
        n_vec++; if (bus_req_valid !== 1'b0 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset valids: got req=%b out=%b want 0/0", bus_req_valid, out_valid); end
        n_vec++; if (out_rdata !== 32'h0 || out_err !== 1'b0) begin n_err++;
            $display("FAIL reset result: got %h/%b want 0/0", out_rdata, out_err); end
        n_vec++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_wmask !== 4'h0 || bus_wen !== 1'b0) begin n_err++;
            $display("FAIL reset bus: got a=%h d=%h m=%b w=%b want zeros", bus_addr, bus_wdata, bus_wmask, bus_wen); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_loads();
        for (int i = 0; i < 7; i++) begin
            n_vec++; if (in_ready !== 1'b1) begin n_err++;
                $display("FAIL load%0d idle ready: got %b want 1", i, in_ready); end
            start_op(1'b1, 1'b0, ld_addr[i], 32'h0, ld_size[i], ld_uns[i]);
            n_vec++; if (bus_req_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++;
                $display("FAIL load%0d req phase: got req=%b busy=%b rdy=%b ov=%b want 1/1/0/0",
                         i, bus_req_valid, busy, in_ready, out_valid); end
            n_vec++; if (bus_addr !== ld_baddr[i]) begin n_err++;
                $display("FAIL load%0d bus_addr: got %h want %h", i, bus_addr, ld_baddr[i]); end
            n_vec++; if (bus_wmask !== 4'b0000 || bus_wen !== 1'b0) begin n_err++;
                $display("FAIL load%0d read mask: got m=%b w=%b want 0000/0", i, bus_wmask, bus_wen); end
            bus_req_ready = 1'b1; tick(); bus_req_ready = 1'b0;
            n_vec++; if (out_valid !== 1'b0 || bus_req_valid !== 1'b0) begin n_err++;
                $display("FAIL load%0d wait phase: got ov=%b req=%b want 0/0", i, out_valid, bus_req_valid); end
            bus_rsp_valid = 1'b1; bus_rdata = ld_rdata[i]; tick();
            bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
            n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++;
                $display("FAIL load%0d latency: got ov=%b rdy=%b want 1/0", i, out_valid, in_ready); end
            n_vec++; if (out_rdata !== ld_exp[i] || out_err !== 1'b0) begin n_err++;
                $display("FAIL load%0d result: got %h err=%b want %h err=0", i, out_rdata, out_err, ld_exp[i]); end
            release_resp();
            n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++;
                $display("FAIL load%0d back idle: got rdy=%b ov=%b want 1/0", i, in_ready, out_valid); end
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 7; i++) begin
            start_op(er_ren[i], er_wen[i], er_addr[i], 32'hFFFF_FFFF, er_size[i], 1'b0);
            n_vec++; if (bus_req_valid !== 1'b0 || out_valid !== 1'b1) begin n_err++;
                $display("FAIL err%0d no-bus path: got req=%b ov=%b want 0/1", i, bus_req_valid, out_valid); end
            n_vec++; if (out_err !== er_exp[i] || out_rdata !== 32'h0) begin n_err++;
                $display("FAIL err%0d result: got err=%b %h want err=%b 0", i, out_err, out_rdata, er_exp[i]); end
            release_resp();
        end
    endtask

    task automatic test_stores();
        for (int i = 0; i < 4; i++) begin
            start_op(1'b0, 1'b1, st_addr[i], st_wdata[i], st_size[i], 1'b0);
            for (int d = 0; d <= st_delay[i]; d++) begin
                n_vec++; if (bus_req_valid !== 1'b1 || bus_wen !== 1'b1) begin n_err++;
                    $display("FAIL st%0d c%0d req: got req=%b wen=%b want 1/1", i, d, bus_req_valid, bus_wen); end
                n_vec++; if (bus_addr !== st_baddr[i] || bus_wdata !== st_bdata[i] || bus_wmask !== st_mask[i]) begin n_err++;
                    $display("FAIL st%0d c%0d fields: got a=%h d=%h m=%b want a=%h d=%h m=%b",
                             i, d, bus_addr, bus_wdata, bus_wmask, st_baddr[i], st_bdata[i], st_mask[i]); end
                if (d == st_delay[i]) bus_req_ready = 1'b1;
                tick();
            end
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b1; bus_rdata = 32'hFFFF_FFFF; tick();
            bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
            n_vec++; if (out_valid !== 1'b1 || out_rdata !== 32'h0 || out_err !== 1'b0) begin n_err++;
                $display("FAIL st%0d ack: got ov=%b %h err=%b want 1 0 0", i, out_valid, out_rdata, out_err); end
            release_resp();
        end
    endtask

    task automatic test_timeout();
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0);
        bus_req_ready = 1'b1; tick(); bus_req_ready = 1'b0;
        for (int w = 0; w < 4; w++) begin
            n_vec++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_err++;
                $display("FAIL timeout wait%0d: got ov=%b busy=%b want 0/1", w, out_valid, busy); end
            tick();
        end
        n_vec++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_rdata !== 32'h0) begin n_err++;
            $display("FAIL timeout resp: got ov=%b err=%b %h want 1 1 0", out_valid, out_err, out_rdata); end
        bus_rsp_valid = 1'b1; bus_rdata = 32'h5555_5555; tick(); bus_rsp_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_rdata !== 32'h0) begin n_err++;
            $display("FAIL late rsp in resp: got ov=%b err=%b %h want 1 1 0", out_valid, out_err, out_rdata); end
        release_resp();
        bus_rsp_valid = 1'b1; tick(); bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
        n_vec++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || bus_req_valid !== 1'b0) begin n_err++;
            $display("FAIL late rsp idle: got rdy=%b busy=%b ov=%b req=%b want 1/0/0/0",
                     in_ready, busy, out_valid, bus_req_valid); end
    endtask

    task automatic test_rsp_at_limit();
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0);
        bus_req_ready = 1'b1; tick(); bus_req_ready = 1'b0;
        tick(); tick(); tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL limit wait3: got ov=%b want 0", out_valid); end
        bus_rsp_valid = 1'b1; bus_rdata = 32'h1122_3344; tick();
        bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
        n_vec++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_rdata !== 32'h1122_3344) begin n_err++;
            $display("FAIL limit rsp wins: got ov=%b err=%b %h want 1 0 11223344", out_valid, out_err, out_rdata); end
        release_resp();
        // Bus error on a load
        start_op(1'b1, 1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0);
        bus_req_ready = 1'b1; tick(); bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1; bus_rsp_err = 1'b1; bus_rdata = 32'h1234_5678; tick();
        bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rdata = 32'h0;
        n_vec++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_rdata !== 32'h0) begin n_err++;
            $display("FAIL bus err: got ov=%b err=%b %h want 1 1 0", out_valid, out_err, out_rdata); end
        release_resp();
    endtask

    task automatic test_backpressure();
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0);
        bus_req_ready = 1'b1; tick(); bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1; bus_rdata = 32'hA5A5_0001; tick();
        bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
        in_valid = 1'b1; in_ren = 1'b0; in_wen = 1'b0; in_size = 2'd0; in_addr = 32'h0;
        for (int c = 0; c < 5; c++) begin
            n_vec++; if (out_valid !== 1'b1 || out_rdata !== 32'hA5A5_0001 || in_ready !== 1'b0) begin n_err++;
                $display("FAIL stall c%0d: got ov=%b %h rdy=%b want 1 a5a50001 0", c, out_valid, out_rdata, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        release_resp();
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL stall release: got rdy=%b ov=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid();
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0);
        bus_req_ready = 1'b1; tick(); bus_req_ready = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        n_vec++; if (in_ready !== 1'b1 || bus_req_valid !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL rst in wait: got rdy=%b req=%b busy=%b ov=%b want 1/0/0/0",
                     in_ready, bus_req_valid, busy, out_valid); end
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'h0, 2'd2, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        n_vec++; if (bus_req_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL rst in req: got req=%b rdy=%b want 0/1", bus_req_valid, in_ready); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_errors();
        test_stores();
        test_timeout();
        test_rsp_at_limit();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_hs.md
Name: lsu_hs

Overview:
- Parametrised load/store unit between EXU and the SimpleBus data port.
- Accepts one memory op per valid/ready handshake from EXU and issues a handshaked bus request.
- Waits a variable number of cycles for the bus response, with a timeout.
- Returns an aligned, sign/zero-extended load result or a write acknowledge to WBU, with an error flag.
- Single outstanding transaction. Replaces the fixed one-cycle-read LSU.

Parameters:
- ADDR_W, 32, address width of EXU and bus addresses.
- TIMEOUT, 255, max WAIT cycles before error response; 0 disables the timeout.
- TO_W, 8, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  EXU op valid
- in_ready  out  1  LSU can accept op
- in_ren  in  1  load
- in_wen  in  1  store
- in_addr  in  ADDR_W  byte address
- in_wdata  in  32  store data, right-aligned
- in_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- in_unsigned  in  1  zero-extend load (LBU/LHU)
- out_valid  out  1  result valid to WBU
- out_ready  in  1  WBU accepts result
- out_rdata  out  32  load result; 0 for stores and errors
- out_err  out  1  misaligned, illegal, bus error or timeout
- busy  out  1  high in every state except IDLE; pipeline stall
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_addr  out  ADDR_W  word-aligned address, in_addr with [1:0]=0
- bus_wen  out  1  write request
- bus_wdata  out  32  lane-replicated store data
- bus_wmask  out  4  byte-lane mask; 0 for reads
- bus_rsp_valid  in  1  response valid, one-cycle pulse
- bus_rdata  in  32  read word
- bus_rsp_err  in  1  bus error with response

Behaviour:
- States: IDLE, REQ, WAIT, RESP. All outputs are registered or decoded from state.
- Reset: state IDLE; all outputs 0 except in_ready=1; timeout counter 0. Reset mid-transaction drops bus_req_valid immediately and discards the op.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready and latch all in_* fields.
  - Error conditions: in_ren&in_wen, or in_size=11, or misaligned (half with addr[0]=1; word with addr[1:0]!=0). On error go to RESP with out_err=1, out_rdata=0; no bus request is issued.
  - Neither ren nor wen: go to RESP with out_err=0, out_rdata=0.
  - Otherwise go to REQ.
- REQ:
  - bus_req_valid=1; bus_addr, bus_wen, bus_wdata and bus_wmask are held stable until bus_req_ready.
  - On handshake go to WAIT and clear the counter.
- Store lanes, with k=addr[1:0]:
  - byte: wdata={4{wdata[7:0]}}, wmask=4'b0001<<k.
  - half: wdata={2{wdata[15:0]}}, wmask=4'b0011<<k.
  - word: wdata unchanged, wmask=1111.
- WAIT:
  - bus_rsp_valid is sampled only in WAIT; the earliest response is the cycle after the request handshake.
  - On response: for loads, out_rdata = extend(bus_rdata >> 8*k, size, unsigned); for stores, out_rdata=0. out_err=bus_rsp_err. Go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT (TIMEOUT!=0): out_err=1, out_rdata=0, go to RESP.
  - A response and the timeout in the same cycle: the response wins.
- RESP:
  - out_valid=1; out_rdata and out_err are held stable until out_ready, then go to IDLE.
  - in_ready=0, so there is no overlap with the next accept.
- Late bus_rsp_valid outside WAIT (after a timeout) is ignored.
- Minimum latency, accept to out_valid: 3 cycles for a bus op (zero-wait bus); 1 cycle for error/no-op.
- Throughput: one op per 4 cycles minimum.

Test Plan:
- LB from addr 0x8000_0003, bus_rdata=0x80AA_BBCC, 0-wait bus:
  - bus_addr=0x8000_0000, bus_wmask=0.
  - out_rdata=0xFFFF_FF80, out_valid 3 cycles after accept.
- LHU from addr 0x8000_0002, same data: out_rdata=0x0000_80AA.
- SB 0x12 to addr 0x8000_0001 with req_ready delayed 2 cycles:
  - bus_wdata=0x1212_1212, bus_wmask=0010, held stable while req_valid is high.
  - out_rdata=0, out_err=0 after the response.
- LW to addr 0x8000_0002: no bus_req_valid; out_valid next cycle with out_err=1.
- TIMEOUT=4, LW with no response: out_err=1 after 4 WAIT cycles; a later bus_rsp_valid is ignored, state is IDLE.
- out_ready held low 5 cycles in RESP: out_valid and out_rdata are stable and in_ready=0. Assert rst during WAIT: next cycle in_ready=1 and bus_req_valid=0.
